or1200_enc_xor_unit: RTL and testbench
======================================

Name: or1200_enc_xor_unit

Overview:
- Sits between the load/store unit (LSU) and the data cache, downstream of the encryption FSM/pad-shift top.
- Consumes its shifted 32-bit load and store pads and its pad-busy stalls (xor_stall_load / xor_stall_store).
- Secure stores: XORs store data with the store pad before the cache write. Secure loads: XORs returned cache data with the load pad before handing it to the LSU.
- Produces the delayed load/store acks that advance the pad engines. Non-secure accesses pass through with 1-cycle request registration.

Parameters:
- PAD_TMO, 255: max cycles to wait for a pad before aborting with err_o; 0 disables the timeout.
- SECURE_SEL_MASK, 1: 1 = XOR only bytes enabled by sel; 0 = XOR the full word.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- lsu_req_i  in  1  access request, held until lsu_ack_o
- lsu_we_i  in  1  1 = store
- lsu_secure_i  in  1  access uses encryption pad
- lsu_addr_i  in  32  address
- lsu_sel_i  in  4  byte selects
- lsu_dat_i  in  32  store data
- lsu_dat_o  out  32  load data, valid with lsu_ack_o
- lsu_ack_o  out  1  1-cycle completion pulse
- err_o  out  1  1-cycle pad-timeout pulse, coincident with lsu_ack_o
- dc_cycstb_o  out  1  cache request
- dc_we_o  out  1  cache write
- dc_addr_o  out  32  cache address
- dc_sel_o  out  4  cache byte selects
- dc_dat_o  out  32  cache write data
- dc_dat_i  in  32  cache read data
- dc_ack_i  in  1  cache ack
- pad_load_i  in  32  shifted load pad
- pad_store_i  in  32  shifted store pad
- pad_busy_load_i  in  1  load pad not ready
- pad_busy_store_i  in  1  store pad not ready
- load_ack_o  out  1  delayed secure-load ack to pad engine
- store_ack_o  out  1  delayed secure-store ack to pad engine

Behaviour:
- Reset: state IDLE; every output 0, including dc_*, lsu_dat_o and the timeout counter. Reset mid-access drops dc_cycstb_o on the next edge and produces no ack.
- IDLE: on lsu_req_i, latch we, secure, addr, sel and data.
  - Store: secure and pad_busy_store_i -> ST_PAD; otherwise -> ST_REQ, with dc_dat_o = data ^ (secure ? mask(pad_store_i) : 0).
  - Load -> LD_REQ.
- ST_PAD: each cycle pad_busy_store_i is high, increment the timeout counter. When busy goes low, compute the XOR from pad_store_i sampled that cycle -> ST_REQ.
- ST_REQ: dc_cycstb_o = dc_we_o = 1. On dc_ack_i: drop the request; lsu_ack_o = 1 the next cycle; if secure, store_ack_o = 1 the same cycle as lsu_ack_o; -> IDLE.
- LD_REQ: dc_cycstb_o = 1, dc_we_o = 0. On dc_ack_i, capture dc_dat_i into the data buffer.
  - Non-secure -> RESP with raw data.
  - Secure, pad ready -> RESP with data ^ mask(pad_load_i).
  - Secure, pad busy -> LD_PAD.
- LD_PAD: increment the counter while busy. On not busy, XOR the buffered data with pad_load_i -> RESP.
- RESP: lsu_ack_o = 1 and lsu_dat_o valid for exactly 1 cycle; load_ack_o = 1 the same cycle if secure; -> IDLE.
- mask(p): when SECURE_SEL_MASK = 1, byte i = sel[i] ? p byte i : 0.
- Timeout: when PAD_TMO != 0 and the counter reaches PAD_TMO while still busy, skip the cache access (store) or return the unXORed buffered data (load); pulse lsu_ack_o and err_o; give no pad ack; -> IDLE. The counter clears on entry to any PAD state.
- lsu_req_i is ignored outside IDLE. Back-to-back requests: a new request can be accepted the cycle after lsu_ack_o.
- Pad busy deasserting in the same cycle the state is entered: treated as ready, so zero extra wait.
- Latency, no pad wait: non-secure and secure store = request cycle + 1 + cache latency + 1; load = request + 1 + cache + 1.
- dc_dat_o and dc_addr_o stay stable while dc_cycstb_o is high.

Optional Feature:
- Macro OR1200_ENC_XOR_STATS_EN.
- Defined:
  - Adds outputs stat_sld_o[15:0] (secure loads completed), stat_sst_o[15:0] (secure stores completed) and stat_stall_o[15:0] (cycles spent in ST_PAD/LD_PAD).
  - All three saturate at 16'hFFFF, reset to 0, and do not count timeouts as completions.
- Undefined: these ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Non-secure store, addr 0x100, data 0xDEADBEEF, sel F, dc_ack 2 cycles after request -> dc_dat_o 0xDEADBEEF, lsu_ack_o once, store_ack_o never.
- Secure store, data 0x12345678, pad_store 0xFFFF0000, busy 0 -> dc_dat_o 0xEDCB5678, store_ack_o coincident with lsu_ack_o.
- Secure store, busy high 5 cycles, pad 0x000000FF -> dc_cycstb_o asserts only after busy falls, data ^ 0xFF, stat_stall_o = 5 with the macro defined.
- Secure load, dc_dat_i 0xA5A5A5A5, pad_load 0x5A5A5A5A, sel 4'b0011 -> lsu_dat_o 0xA5A5FFFF, load_ack_o pulses once.
- PAD_TMO = 4, secure load with busy stuck high -> lsu_ack_o and err_o pulse 4 cycles after entering LD_PAD with raw data; load_ack_o stays 0.
- Reset asserted while in ST_REQ -> dc_cycstb_o = 0 on the next edge, no lsu_ack_o; the next non-secure load completes normally.

Source files
------------

// File: rtl/or1200_enc_xor_unit.sv
// XOR stage between the LSU and the data cache: applies load/store encryption pads.
// Optional OR1200_ENC_XOR_STATS_EN adds saturating secure-access and pad-stall counters.
module or1200_enc_xor_unit #(
  parameter int unsigned PAD_TMO         = 255,
  parameter int unsigned SECURE_SEL_MASK = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic        lsu_secure_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [3:0]  lsu_sel_i,
  input  logic [31:0] lsu_dat_i,
  output logic [31:0] lsu_dat_o,
  output logic        lsu_ack_o,
  output logic        err_o,
  output logic        dc_cycstb_o,
  output logic        dc_we_o,
  output logic [31:0] dc_addr_o,
  output logic [3:0]  dc_sel_o,
  output logic [31:0] dc_dat_o,
  input  logic [31:0] dc_dat_i,
  input  logic        dc_ack_i,
  input  logic [31:0] pad_load_i,
  input  logic [31:0] pad_store_i,
  input  logic        pad_busy_load_i,
  input  logic        pad_busy_store_i,
  output logic        load_ack_o,
  output logic        store_ack_o
`ifdef OR1200_ENC_XOR_STATS_EN
  ,
  output logic [15:0] stat_sld_o,
  output logic [15:0] stat_sst_o,
  output logic [15:0] stat_stall_o
`endif
);

  localparam int unsigned CW = (PAD_TMO > 1) ? $clog2(PAD_TMO) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(PAD_TMO - 1);

  typedef enum logic [2:0] {IDLE, ST_PAD, ST_REQ, LD_REQ, LD_PAD, RESP} state_t;

  state_t        state;
  logic          sec_q;
  logic [31:0]   dat_q;
  logic [31:0]   buf_q;
  logic [CW-1:0] cnt;
  logic          tmo_hit;

  function automatic logic [31:0] pad_mask(input logic [31:0] p, input logic [3:0] s);
    logic [31:0] m;
    for (int unsigned i = 0; i < 4; i++)
      m[8*i +: 8] = (SECURE_SEL_MASK == 0 || s[i]) ? p[8*i +: 8] : 8'h00;
    return m;
  endfunction

  // Counter has reached its last busy cycle: this busy cycle aborts the access.
  assign tmo_hit = (PAD_TMO != 0) && (cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sec_q       <= 1'b0;
      dat_q       <= '0;
      buf_q       <= '0;
      cnt         <= '0;
      lsu_dat_o   <= '0;
      lsu_ack_o   <= 1'b0;
      err_o       <= 1'b0;
      dc_cycstb_o <= 1'b0;
      dc_we_o     <= 1'b0;
      dc_addr_o   <= '0;
      dc_sel_o    <= '0;
      dc_dat_o    <= '0;
      load_ack_o  <= 1'b0;
      store_ack_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (lsu_req_i) begin
            sec_q     <= lsu_secure_i;
            dat_q     <= lsu_dat_i;
            dc_addr_o <= lsu_addr_i;
            dc_sel_o  <= lsu_sel_i;
            cnt       <= '0;
            if (lsu_we_i) begin
              if (lsu_secure_i && pad_busy_store_i) begin
                state <= ST_PAD;
              end else begin
                dc_dat_o    <= lsu_dat_i ^ (lsu_secure_i ? pad_mask(pad_store_i, lsu_sel_i) : '0);
                dc_cycstb_o <= 1'b1;
                dc_we_o     <= 1'b1;
                state       <= ST_REQ;
              end
            end else begin
              dc_cycstb_o <= 1'b1;
              dc_we_o     <= 1'b0;
              state       <= LD_REQ;
            end
          end
        end
        ST_PAD: begin
          if (!pad_busy_store_i) begin
            dc_dat_o    <= dat_q ^ pad_mask(pad_store_i, dc_sel_o);
            dc_cycstb_o <= 1'b1;
            dc_we_o     <= 1'b1;
            state       <= ST_REQ;
          end else if (tmo_hit) begin
            lsu_ack_o <= 1'b1;
            err_o     <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_REQ: begin
          if (dc_ack_i) begin
            dc_cycstb_o <= 1'b0;
            dc_we_o     <= 1'b0;
            lsu_ack_o   <= 1'b1;
            store_ack_o <= sec_q;
            state       <= RESP;
          end
        end
        LD_REQ: begin
          if (dc_ack_i) begin
            dc_cycstb_o <= 1'b0;
            buf_q       <= dc_dat_i;
            cnt         <= '0;
            if (!sec_q) begin
              lsu_dat_o <= dc_dat_i;
              lsu_ack_o <= 1'b1;
              state     <= RESP;
            end else if (!pad_busy_load_i) begin
              lsu_dat_o  <= dc_dat_i ^ pad_mask(pad_load_i, dc_sel_o);
              lsu_ack_o  <= 1'b1;
              load_ack_o <= 1'b1;
              state      <= RESP;
            end else begin
              state <= LD_PAD;
            end
          end
        end
        LD_PAD: begin
          if (!pad_busy_load_i) begin
            lsu_dat_o  <= buf_q ^ pad_mask(pad_load_i, dc_sel_o);
            lsu_ack_o  <= 1'b1;
            load_ack_o <= 1'b1;
            state      <= RESP;
          end else if (tmo_hit) begin
            lsu_dat_o <= buf_q;
            lsu_ack_o <= 1'b1;
            err_o     <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          // Ack cycle: the LSU still holds its request, so acceptance waits for IDLE.
          lsu_ack_o   <= 1'b0;
          err_o       <= 1'b0;
          load_ack_o  <= 1'b0;
          store_ack_o <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef OR1200_ENC_XOR_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_sld_o   <= '0;
      stat_sst_o   <= '0;
      stat_stall_o <= '0;
    end else begin
      if (load_ack_o && stat_sld_o != '1)
        stat_sld_o <= stat_sld_o + 1'b1;
      if (store_ack_o && stat_sst_o != '1)
        stat_sst_o <= stat_sst_o + 1'b1;
      if (((state == ST_PAD && pad_busy_store_i) || (state == LD_PAD && pad_busy_load_i))
          && stat_stall_o != '1)
        stat_stall_o <= stat_stall_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_or1200_enc_xor_unit.sv
// Self-checking bench for or1200_enc_xor_unit: directed cases plus random transactions
// checked against a transaction-level timing/data model.
module tb_or1200_enc_xor_unit;

  localparam int unsigned TMO = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_req_i, lsu_we_i, lsu_secure_i;
  logic [31:0] lsu_addr_i, lsu_dat_i, lsu_dat_o;
  logic [3:0]  lsu_sel_i;
  logic        lsu_ack_o, err_o;
  logic        dc_cycstb_o, dc_we_o;
  logic [31:0] dc_addr_o, dc_dat_o, dc_dat_i;
  logic [3:0]  dc_sel_o;
  logic        dc_ack_i;
  logic [31:0] pad_load_i, pad_store_i;
  logic        pad_busy_load_i, pad_busy_store_i;
  logic        load_ack_o, store_ack_o;
`ifdef OR1200_ENC_XOR_STATS_EN
  logic [15:0] stat_sld_o, stat_sst_o, stat_stall_o;
`endif

  or1200_enc_xor_unit #(.PAD_TMO(TMO), .SECURE_SEL_MASK(1)) dut (
    .clk(clk), .rst(rst),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_secure_i(lsu_secure_i),
    .lsu_addr_i(lsu_addr_i), .lsu_sel_i(lsu_sel_i), .lsu_dat_i(lsu_dat_i),
    .lsu_dat_o(lsu_dat_o), .lsu_ack_o(lsu_ack_o), .err_o(err_o),
    .dc_cycstb_o(dc_cycstb_o), .dc_we_o(dc_we_o), .dc_addr_o(dc_addr_o),
    .dc_sel_o(dc_sel_o), .dc_dat_o(dc_dat_o), .dc_dat_i(dc_dat_i), .dc_ack_i(dc_ack_i),
    .pad_load_i(pad_load_i), .pad_store_i(pad_store_i),
    .pad_busy_load_i(pad_busy_load_i), .pad_busy_store_i(pad_busy_store_i),
    .load_ack_o(load_ack_o), .store_ack_o(store_ack_o)
`ifdef OR1200_ENC_XOR_STATS_EN
    , .stat_sld_o(stat_sld_o), .stat_sst_o(stat_sst_o), .stat_stall_o(stat_stall_o)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned exp_sld = 0, exp_sst = 0, exp_stall = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_mask(input logic [31:0] p, input logic [3:0] s);
    logic [31:0] m = '0;
    for (int i = 0; i < 4; i++)
      if (s[i]) m = m + (p & (32'hFF << (8 * i)));
    return m;
  endfunction

  // Cycle 0 is the request cycle; busy is high during cycles 0..busy-1; the cache acks
  // in the lat-th cycle of the cache request.
  task automatic run_txn(input logic we, input logic sec, input logic [31:0] addr,
                         input logic [3:0] sel, input logic [31:0] wdata,
                         input logic [31:0] rdata, input logic [31:0] pst,
                         input logic [31:0] pld, input int unsigned lat,
                         input int unsigned busy);
    int unsigned pad_wait, exp_s, exp_ack;
    int unsigned c = 0, stb_run = 0, acks = 0, ack_c = 0, errs = 0, lacks = 0, sacks = 0;
    int unsigned first_s = 0;
    logic        tmo;
    logic        stable = 1'b1, err_co = 1'b0, sa_co = 1'b0, la_co = 1'b0, st_we = 1'b0;
    logic [31:0] got_dat = '0, st_dat = '0, st_addr = '0;
    logic [3:0]  st_sel = '0;

    if (we) begin
      pad_wait = (sec && busy > 0) ? busy - 1 : 0;
      tmo      = sec && busy > 0 && pad_wait >= TMO;
      exp_s    = (sec && busy > 0) ? busy + 1 : 1;
      exp_ack  = tmo ? TMO + 1 : exp_s + lat;
    end else begin
      pad_wait = (sec && busy > lat) ? busy - 1 - lat : 0;
      tmo      = sec && busy > lat && pad_wait >= TMO;
      exp_s    = 1;
      exp_ack  = tmo ? lat + TMO + 1 : ((sec && busy > lat) ? busy + 1 : lat + 1);
    end
    exp_stall += tmo ? TMO : pad_wait;
    if (sec && !tmo) begin
      if (we) exp_sst++;
      else    exp_sld++;
    end

    lsu_req_i = 1'b1; lsu_we_i = we; lsu_secure_i = sec; lsu_addr_i = addr;
    lsu_sel_i = sel;  lsu_dat_i = wdata; pad_store_i = pst; pad_load_i = pld;
    dc_ack_i = 1'b0;  dc_dat_i = $urandom;
    pad_busy_store_i = we ? (busy > 0) : 1'($urandom);
    pad_busy_load_i  = we ? 1'($urandom) : (busy > 0);

    while (c < 60 && !(acks > 0 && c == ack_c + 1)) begin
      @(posedge clk); c++;
      @(negedge clk);
      if (dc_cycstb_o) begin
        stb_run++;
        if (stb_run == 1) begin
          first_s = c; st_dat = dc_dat_o; st_addr = dc_addr_o; st_sel = dc_sel_o; st_we = dc_we_o;
        end else if (dc_dat_o !== st_dat || dc_addr_o !== st_addr) begin
          stable = 1'b0;
        end
      end
      if (lsu_ack_o) begin
        acks++;
        if (acks == 1) begin
          ack_c = c; got_dat = lsu_dat_o; err_co = err_o; sa_co = store_ack_o; la_co = load_ack_o;
        end
      end
      errs  += 32'(err_o);
      lacks += 32'(load_ack_o);
      sacks += 32'(store_ack_o);
      dc_ack_i = dc_cycstb_o && stb_run == lat;
      dc_dat_i = dc_ack_i ? rdata : $urandom;
      if (we) begin
        pad_busy_store_i = c < busy; pad_busy_load_i = 1'($urandom);
      end else begin
        pad_busy_load_i = c < busy;  pad_busy_store_i = 1'($urandom);
      end
      if (acks > 0 && c > ack_c) lsu_req_i = 1'b0;
    end
    lsu_req_i = 1'b0; dc_ack_i = 1'b0; pad_busy_load_i = 1'b0; pad_busy_store_i = 1'b0;

    check("ack_count", acks, 1);
    check("ack_cycle", ack_c, exp_ack);
    check("err_count", errs, 32'(tmo));
    check("err_at_ack", 32'(err_co), 32'(tmo));
    if (we) begin
      check("store_ack_count", sacks, 32'(sec && !tmo));
      check("store_ack_at_ack", 32'(sa_co), 32'(sec && !tmo));
      check("load_ack_on_store", lacks, 0);
      if (tmo) begin
        check("stb_on_timeout", stb_run, 0);
      end else begin
        check("stb_start", first_s, exp_s);
        check("stb_cycles", stb_run, lat);
        check("dc_dat", st_dat, sec ? (wdata ^ ref_mask(pst, sel)) : wdata);
        check("dc_we", 32'(st_we), 1);
        check("dc_addr", st_addr, addr);
        check("dc_sel", 32'(st_sel), 32'(sel));
        check("dc_stable", 32'(stable), 1);
      end
    end else begin
      check("load_ack_count", lacks, 32'(sec && !tmo));
      check("load_ack_at_ack", 32'(la_co), 32'(sec && !tmo));
      check("store_ack_on_load", sacks, 0);
      check("stb_start", first_s, 1);
      check("stb_cycles", stb_run, lat);
      check("dc_we", 32'(st_we), 0);
      check("dc_addr", st_addr, addr);
      check("dc_sel", 32'(st_sel), 32'(sel));
      check("lsu_dat", got_dat, (sec && !tmo) ? (rdata ^ ref_mask(pld, sel)) : rdata);
    end
  endtask

  initial begin
    int unsigned seen;
    rst = 1'b1; lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_secure_i = 1'b0;
    lsu_addr_i = '0; lsu_sel_i = '0; lsu_dat_i = '0; dc_dat_i = '0; dc_ack_i = 1'b0;
    pad_load_i = '0; pad_store_i = '0; pad_busy_load_i = 1'b0; pad_busy_store_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_acks", {28'd0, lsu_ack_o, err_o, load_ack_o, store_ack_o}, 0);
    check("rst_dc_ctl", {30'd0, dc_cycstb_o, dc_we_o}, 0);
    check("rst_dc_addr", dc_addr_o, 0);
    check("rst_dc_dat", dc_dat_o, 0);
    check("rst_dc_sel", 32'(dc_sel_o), 0);
    check("rst_lsu_dat", lsu_dat_o, 0);
`ifdef OR1200_ENC_XOR_STATS_EN
    check("rst_stats", {stat_sld_o, stat_sst_o} | 32'(stat_stall_o), 0);
`endif
    rst = 1'b0;

    run_txn(1'b1, 1'b0, 32'h100, 4'hF, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 2, 0);
    run_txn(1'b1, 1'b1, 32'h104, 4'hF, 32'h12345678, 32'h0, 32'hFFFF0000, 32'h0, 1, 0);
    run_txn(1'b1, 1'b1, 32'h108, 4'hF, 32'hCAFEF00D, 32'h0, 32'h000000FF, 32'h0, 2, 6);
    run_txn(1'b0, 1'b1, 32'h10C, 4'b0011, 32'h0, 32'hA5A5A5A5, 32'h0, 32'h5A5A5A5A, 1, 0);
    run_txn(1'b0, 1'b1, 32'h110, 4'hF, 32'h0, 32'h13579BDF, 32'h0, 32'hFFFFFFFF, 1, 100);
    run_txn(1'b1, 1'b1, 32'h114, 4'hF, 32'h0BADF00D, 32'h0, 32'h11111111, 32'h0, 1, 100);
    run_txn(1'b0, 1'b1, 32'h118, 4'b1010, 32'h0, 32'h76543210, 32'h0, 32'h0F0F0F0F, 2, 4);

    for (int n = 0; n < 40; n++)
      run_txn(1'($urandom), 1'($urandom), $urandom, 4'($urandom_range(1, 15)), $urandom,
              $urandom, $urandom, $urandom, $urandom_range(1, 4), $urandom_range(0, 10));

`ifdef OR1200_ENC_XOR_STATS_EN
    check("stat_sld", 32'(stat_sld_o), exp_sld);
    check("stat_sst", 32'(stat_sst_o), exp_sst);
    check("stat_stall", 32'(stat_stall_o), exp_stall);
`endif

    // Reset while a store is waiting in the cache request phase.
    lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_secure_i = 1'b0; lsu_addr_i = 32'h200;
    lsu_sel_i = 4'hF; lsu_dat_i = 32'h55AA55AA; dc_ack_i = 1'b0;
    for (int i = 0; i < 10 && !dc_cycstb_o; i++) begin
      @(posedge clk); @(negedge clk);
    end
    check("pre_rst_stb", 32'(dc_cycstb_o), 1);
    rst = 1'b1; lsu_req_i = 1'b0;
    @(posedge clk); @(negedge clk);
    check("mid_rst_stb", 32'(dc_cycstb_o), 0);
    check("mid_rst_ack", 32'(lsu_ack_o), 0);
    rst = 1'b0;
    seen = 0;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      seen += 32'(lsu_ack_o | dc_cycstb_o);
    end
    check("post_rst_quiet", seen, 0);
    exp_sld = 0; exp_sst = 0; exp_stall = 0;
    run_txn(1'b0, 1'b0, 32'h204, 4'hF, 32'h0, 32'h89ABCDEF, 32'h0, 32'h0, 3, 0);
`ifdef OR1200_ENC_XOR_STATS_EN
    check("stat_after_rst", {stat_sld_o, stat_sst_o} | 32'(stat_stall_o), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
